// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder
// ----------------------------------------------------------------------------
// Word-organised data memory that serves the data port of the single-cycle
// issue MIPS core. The core presents a byte address every cycle, either with a
// write enable and data, or as a read. Read data comes back through a short
// shift pipeline of RD_LAT stages. A bench-side preload port can write any word
// directly. Misaligned or out-of-range accesses are reported with a one-cycle
// error pulse, and the count of committed core writes is exposed.
//
// Parameters:
//   ADDR_W  - byte-address width
//   DATA_W  - data word width
//   DEPTH   - number of words (power of two, 4..1024)
//   RD_LAT  - read latency in cycles (1..4)
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_d_wen        core write enable (1 = write, 0 = read)
//   i_d_addr       core byte address
//   i_d_wdata      core write data
//   o_d_rdata      read data (last stage of the read pipeline)
//   o_rdata_valid  o_d_rdata holds the result of a legal read
//   o_addr_err     one-cycle pulse following an illegal access
//   i_ld_en        preload enable
//   i_ld_idx       preload word index
//   i_ld_data      preload data
//   o_wr_cnt       saturating count of committed core writes
//
// Build option:
//   DMEM_BYPASS_EN - when defined, a legal read to a word that is being
//                    written in the same cycle returns the new data instead
//                    of the old contents.
// ============================================================================
module dmem_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_d_wen,
    input  logic [ADDR_W-1:0]        i_d_addr,
    input  logic [DATA_W-1:0]        i_d_wdata,
    output logic [DATA_W-1:0]        o_d_rdata,
    output logic                     o_rdata_valid,
    output logic                     o_addr_err,
    input  logic                     i_ld_en,
    input  logic [$clog2(DEPTH)-1:0] i_ld_idx,
    input  logic [DATA_W-1:0]        i_ld_data,
    output logic [15:0]              o_wr_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] pipe_data [RD_LAT];
    logic [RD_LAT-1:0] pipe_valid;

    logic [IDX_W-1:0]  idx;
    logic              aligned;
    logic              in_range;
    logic              legal;
    logic              core_wr;
    logic [DATA_W-1:0] fetch_data;
    logic [DATA_W-1:0] stage0_data;
    logic              stage0_valid;

    // Address decode. The word index is taken from the bits just above the
    // byte offset; every bit above the index must be zero, so addresses at or
    // beyond DEPTH*4 are rejected instead of silently wrapping onto low words.
    assign idx      = i_d_addr[IDX_W+1:2];
    assign aligned  = (i_d_addr[1:0] == 2'b00);
    assign in_range = ((i_d_addr >> (IDX_W + 2)) == '0);
    assign legal    = aligned && in_range;
    assign core_wr  = i_d_wen && legal;

    // Word returned by a read this cycle. The core has a single address port,
    // so a core read never coincides with a core write; the only same-cycle
    // write a read can collide with is a preload.
`ifdef DMEM_BYPASS_EN
    always_comb begin
        fetch_data = mem[idx];
        if (i_ld_en && (i_ld_idx == idx)) begin
            fetch_data = i_ld_data;
        end
    end
`else
    assign fetch_data = mem[idx];
`endif

    // Next value of pipeline stage 0. Legal reads load memory data with valid
    // set; illegal reads push zero data with valid clear; write cycles leave
    // the data untouched so the output keeps its last value, with valid clear.
    always_comb begin
        stage0_data  = pipe_data[0];
        stage0_valid = 1'b0;
        if (!i_d_wen) begin
            if (legal) begin
                stage0_data  = fetch_data;
                stage0_valid = 1'b1;
            end else begin
                stage0_data = '0;
            end
        end
    end

    // Memory array. Core write goes first and the preload second, so when both
    // target the same word the preload data is what lands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (core_wr) begin
                mem[idx] <= i_d_wdata;
            end
            if (i_ld_en) begin
                mem[i_ld_idx] <= i_ld_data;
            end
        end
    end

    // Read pipeline. Stage 0 captures the current access; later stages simply
    // shift. Reset empties every stage so an in-flight read is lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_data[i] <= '0;
            end
            pipe_valid <= '0;
        end else begin
            pipe_data[0]  <= stage0_data;
            pipe_valid[0] <= stage0_valid;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_data[i]  <= pipe_data[i-1];
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // Error pulse and write counter. The error flag is recomputed every cycle,
    // so it stays high only for the cycle after the offending access.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_addr_err <= 1'b0;
            o_wr_cnt   <= '0;
        end else begin
            o_addr_err <= !legal;
            if (core_wr && (o_wr_cnt != 16'hFFFF)) begin
                o_wr_cnt <= o_wr_cnt + 16'd1;
            end
        end
    end

    assign o_d_rdata     = pipe_data[RD_LAT-1];
    assign o_rdata_valid = pipe_valid[RD_LAT-1];

endmodule
